// File: rtl/fwd_hazard_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_if
// Bundle of pipeline-side signals seen by the forwarding / load-use hazard unit.
//
// Parameters:
//   REG_AW  - register-address width in bits
//   NUM_SRC - source operands per instruction (1..4)
//
// Signals (packed operand i at [i*REG_AW +: REG_AW], select i at [2i+1:2i]):
//   id_rs, id_rs_used        ID-stage source registers and their use flags
//   ex_rs, ex_memread, ex_rd EX-stage sources, load flag and destination
//   mem_regwrite, mem_rd     EX/MEM writeback enable and destination
//   wb_regwrite, wb_rd       MEM/WB writeback enable and destination
//   flush_i                  taken branch/jump, kills IF/ID and ID/EX
//   fwd_sel                  per-operand forwarding mux select
//   stall_pc, stall_ifid     hold PC / IF-ID register
//   flush_idex               load a bubble into ID/EX
//
// Modports: master = pipeline side, slave = hazard unit.
// -----------------------------------------------------------------------------
interface fwd_hazard_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic                      ex_memread;
    logic [REG_AW-1:0]         ex_rd;
    logic                      mem_regwrite;
    logic [REG_AW-1:0]         mem_rd;
    logic                      wb_regwrite;
    logic [REG_AW-1:0]         wb_rd;
    logic                      flush_i;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall_pc;
    logic                      stall_ifid;
    logic                      flush_idex;

    modport master (
        output id_rs, id_rs_used, ex_rs, ex_memread, ex_rd,
               mem_regwrite, mem_rd, wb_regwrite, wb_rd, flush_i,
        input  fwd_sel, stall_pc, stall_ifid, flush_idex
    );

    modport slave (
        input  id_rs, id_rs_used, ex_rs, ex_memread, ex_rd,
               mem_regwrite, mem_rd, wb_regwrite, wb_rd, flush_i,
        output fwd_sel, stall_pc, stall_ifid, flush_idex
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Operand forwarding (EX/MEM over MEM/WB, register 0 never forwarded) plus a
// load-use stall controller that inserts LOAD_LAT bubbles per hazard. A flush
// aborts any stall and forces a bubble into ID/EX.
//
// Parameters:
//   REG_AW   - register-address width (must match the interface)
//   NUM_SRC  - source operands per instruction, 1..4 (must match the interface)
//   LOAD_LAT - bubbles per load-use hazard, 1..7
//
// Ports:
//   clk   - core clock, rising edge
//   rst_n - synchronous active-low reset; all outputs held 0 while low
//   bus   - fwd_hazard_if.slave (pipeline inputs, forwarding/stall outputs)
//   stall_cnt (only with `define STALL_CNT_EN) - saturating count of cycles
//             with stall_pc asserted
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  bus
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 hazard;
    logic [2*NUM_SRC-1:0] fwd_raw;

    // Forwarding selects from live inputs; EX/MEM wins over MEM/WB.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        fwd_raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.mem_regwrite && (bus.mem_rd != '0) &&
                (bus.mem_rd == bus.ex_rs[i*REG_AW +: REG_AW])) begin
                fwd_raw[2*i +: 2] = 2'b10;
            end else if (bus.wb_regwrite && (bus.wb_rd != '0) &&
                         (bus.wb_rd == bus.ex_rs[i*REG_AW +: REG_AW])) begin
                fwd_raw[2*i +: 2] = 2'b01;
            end
        end
    end

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        hazard = 1'b0;
        if (bus.ex_memread && (bus.ex_rd != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.id_rs_used[i] && (bus.id_rs[i*REG_AW +: REG_AW] == bus.ex_rd)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. The IDLE cycle that detects the hazard is the first
    // bubble, so STALL only covers the remaining LOAD_LAT-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output logic. Reset masks everything; flush beats any stall request.
    always_comb begin
        bus.fwd_sel    = '0;
        bus.stall_pc   = 1'b0;
        bus.stall_ifid = 1'b0;
        bus.flush_idex = 1'b0;
        if (rst_n) begin
            bus.fwd_sel = fwd_raw;
            if (bus.flush_i) begin
                bus.flush_idex = 1'b1;
            end else if ((state == STALL) || ((state == IDLE) && hazard)) begin
                bus.stall_pc   = 1'b1;
                bus.stall_ifid = 1'b1;
                bus.flush_idex = 1'b1;
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.stall_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Drives two hazard units (LOAD_LAT=1 and LOAD_LAT=3) from the same pipeline
// inputs and compares them every cycle with a reference model that tracks
// "bubbles still owed" per unit. Directed sequences cover forwarding priority,
// register 0, load-use lengths, flush abort and reset during a stall; a
// randomized phase follows. Define STALL_CNT_EN to also check stall_cnt.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(AW), .NUM_SRC(NS)) bus_a ();
    fwd_hazard_if #(.REG_AW(AW), .NUM_SRC(NS)) bus_b ();

    assign bus_b.id_rs        = bus_a.id_rs;
    assign bus_b.id_rs_used   = bus_a.id_rs_used;
    assign bus_b.ex_rs        = bus_a.ex_rs;
    assign bus_b.ex_memread   = bus_a.ex_memread;
    assign bus_b.ex_rd        = bus_a.ex_rd;
    assign bus_b.mem_regwrite = bus_a.mem_regwrite;
    assign bus_b.mem_rd       = bus_a.mem_rd;
    assign bus_b.wb_regwrite  = bus_a.wb_regwrite;
    assign bus_b.wb_rd        = bus_a.wb_rd;
    assign bus_b.flush_i      = bus_a.flush_i;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_a, stall_cnt_b;
`endif

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt_a)
`endif
    );

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt_b)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: bubbles still owed after the current cycle, stall counts.
    int rem_a  = 0;
    int rem_b  = 0;
    int scnt_a = 0;
    int scnt_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_fwd();
        int r   = 0;
        int ex  = int'(bus_a.ex_rs);
        int src;
        if (!rst_n) return 0;
        for (int i = 0; i < NS; i++) begin
            src = (ex >> (AW * i)) % 32;
            if (bus_a.mem_regwrite && bus_a.mem_rd != 0 && int'(bus_a.mem_rd) == src)
                r = r + (2 << (2 * i));
            else if (bus_a.wb_regwrite && bus_a.wb_rd != 0 && int'(bus_a.wb_rd) == src)
                r = r + (1 << (2 * i));
        end
        return r;
    endfunction

    function automatic bit model_hazard();
        int id = int'(bus_a.id_rs);
        int rd = int'(bus_a.ex_rd);
        if (!bus_a.ex_memread || rd == 0) return 1'b0;
        for (int i = 0; i < NS; i++)
            if (bus_a.id_rs_used[i] && ((id >> (AW * i)) % 32) == rd) return 1'b1;
        return 1'b0;
    endfunction

    // {stall_pc, stall_ifid, flush_idex}
    function automatic logic [2:0] model_stall(input int rem, input bit hz);
        if (!rst_n)       return 3'b000;
        if (bus_a.flush_i) return 3'b001;
        if (rem > 0 || hz) return 3'b111;
        return 3'b000;
    endfunction

    function automatic int next_rem(input int rem, input bit hz, input int lat);
        if (bus_a.flush_i) return 0;
        if (rem > 0)       return rem - 1;
        if (hz)            return lat - 1;
        return 0;
    endfunction

    // Rising edge: advance the model with the inputs held across the edge.
    task automatic step();
        bit hz;
        logic [2:0] ea, eb;
        @(posedge clk);
        hz = model_hazard();
        ea = model_stall(rem_a, hz);
        eb = model_stall(rem_b, hz);
        if (!rst_n) begin
            rem_a = 0; rem_b = 0; scnt_a = 0; scnt_b = 0;
        end else begin
            if (ea[2]) scnt_a++;
            if (eb[2]) scnt_b++;
            rem_a = next_rem(rem_a, hz, 1);
            rem_b = next_rem(rem_b, hz, 3);
        end
        #1;
    endtask

    // Mid-cycle comparison of both units against the model.
    task automatic check_outputs(input string tag);
        bit hz;
        #2;
        hz = model_hazard();
        check({tag, "/fwd_a"}, 32'(bus_a.fwd_sel), 32'(model_fwd()));
        check({tag, "/fwd_b"}, 32'(bus_b.fwd_sel), 32'(model_fwd()));
        check({tag, "/stall_a"}, 32'({bus_a.stall_pc, bus_a.stall_ifid, bus_a.flush_idex}),
              32'(model_stall(rem_a, hz)));
        check({tag, "/stall_b"}, 32'({bus_b.stall_pc, bus_b.stall_ifid, bus_b.flush_idex}),
              32'(model_stall(rem_b, hz)));
`ifdef STALL_CNT_EN
        check({tag, "/cnt_a"}, stall_cnt_a, 32'(scnt_a));
        check({tag, "/cnt_b"}, stall_cnt_b, 32'(scnt_b));
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        bus_a.id_rs        = '0;
        bus_a.id_rs_used   = '0;
        bus_a.ex_rs        = '0;
        bus_a.ex_memread   = 1'b0;
        bus_a.ex_rd        = '0;
        bus_a.mem_regwrite = 1'b0;
        bus_a.mem_rd       = '0;
        bus_a.wb_regwrite  = 1'b0;
        bus_a.wb_rd        = '0;
        bus_a.flush_i      = 1'b0;
    endtask

    // Load to r7 in EX, ID reads r7 on operand 1 (operand 0 = r3).
    task automatic set_load_use();
        bus_a.ex_memread = 1'b1;
        bus_a.ex_rd      = 5'd7;
        bus_a.id_rs      = {5'd7, 5'd3};
        bus_a.id_rs_used = 2'b10;
    endtask

    int stall_len;

    initial begin
        // Reset: outputs forced 0 even with a forwarding match present.
        set_idle();
        rst_n = 1'b0;
        bus_a.mem_regwrite = 1'b1;
        bus_a.mem_rd       = 5'd5;
        bus_a.ex_rs        = {5'd5, 5'd5};
        set_load_use();
        check_outputs("reset");
        check("reset_fwd", 32'(bus_a.fwd_sel), 32'h0);
        check("reset_stall", 32'(bus_b.stall_pc), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        set_idle();

        // Forwarding priority and register 0.
        bus_a.mem_regwrite = 1'b1; bus_a.mem_rd = 5'd5;
        bus_a.wb_regwrite  = 1'b1; bus_a.wb_rd  = 5'd5;
        bus_a.ex_rs = {5'd5, 5'd5};
        check_outputs("prio_mem");
        check("prio_mem_sel", 32'(bus_a.fwd_sel), 32'h0000_000A);
        step();
        bus_a.mem_regwrite = 1'b0;
        check_outputs("prio_wb");
        check("prio_wb_sel", 32'(bus_a.fwd_sel), 32'h0000_0005);
        step();
        bus_a.mem_regwrite = 1'b1; bus_a.mem_rd = '0; bus_a.wb_rd = '0;
        bus_a.ex_rs = '0;
        check_outputs("reg0");
        check("reg0_sel", 32'(bus_a.fwd_sel), 32'h0);
        step();

        // Load-use, LOAD_LAT=1: one bubble, then ID advances.
        set_idle();
        set_load_use();
        check_outputs("lu1_hit");
        check("lu1_hit_pc", 32'(bus_a.stall_pc), 32'h1);
        step();
        set_idle();
        check_outputs("lu1_after");
        check("lu1_after_pc", 32'(bus_a.stall_pc), 32'h0);
        step();
        repeat (3) begin check_outputs("drain"); step(); end

        // Load-use, LOAD_LAT=3: hazard held while ID is stalled.
        stall_len = 0;
        set_load_use();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) set_idle();
            check_outputs("lu3");
            stall_len += int'(bus_b.stall_pc);
            step();
        end
        check("lu3_len", 32'(stall_len), 32'd3);

        // Operand 1 not read: no hazard.
        set_load_use();
        bus_a.id_rs_used = 2'b01;
        check_outputs("lu_unused");
        check("lu_unused_pc", 32'(bus_b.stall_pc), 32'h0);
        step();

        // Flush on the second stall cycle aborts the stall.
        set_idle();
        stall_len = 0;
        set_load_use();
        check_outputs("fl_first");
        stall_len += int'(bus_b.stall_pc);
        step();
        bus_a.flush_i = 1'b1;
        check_outputs("fl_abort");
        check("fl_abort_pc", 32'(bus_b.stall_pc), 32'h0);
        check("fl_abort_idex", 32'(bus_b.flush_idex), 32'h1);
        stall_len += int'(bus_b.stall_pc);
        step();
        set_idle();
        repeat (3) begin
            check_outputs("fl_after");
            stall_len += int'(bus_b.stall_pc);
            step();
        end
        check("fl_total", 32'(stall_len), 32'd1);

        // Reset for one edge during STALL abandons the remaining bubbles.
        set_load_use();
        check_outputs("rs_first");
        step();
        rst_n = 1'b0;
        check_outputs("rs_low");
        check("rs_low_outs", 32'({bus_b.fwd_sel, bus_b.stall_pc, bus_b.stall_ifid, bus_b.flush_idex}), 32'h0);
        step();
        rst_n = 1'b1;
        set_idle();
        check_outputs("rs_release");
        check("rs_release_pc", 32'(bus_b.stall_pc), 32'h0);
        step();

`ifdef STALL_CNT_EN
        // Two LOAD_LAT=3 hazards after reset count six stall cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) begin
            set_load_use();
            check_outputs("cnt_hit");
            step();
            set_idle();
            repeat (4) begin check_outputs("cnt_drain"); step(); end
        end
        check("stall_cnt_b", stall_cnt_b, 32'd6);
        check("stall_cnt_a", stall_cnt_a, 32'd2);
`endif

        // Randomized phase.
        for (int n = 0; n < 400; n++) begin
            rst_n              = ($urandom_range(0, 49) != 0);
            bus_a.id_rs        = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus_a.id_rs_used   = NS'($urandom_range(0, 3));
            bus_a.ex_rs        = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus_a.ex_memread   = ($urandom_range(0, 2) == 0);
            bus_a.ex_rd        = AW'($urandom_range(0, 7));
            bus_a.mem_regwrite = 1'($urandom_range(0, 1));
            bus_a.mem_rd       = AW'($urandom_range(0, 7));
            bus_a.wb_regwrite  = 1'($urandom_range(0, 1));
            bus_a.wb_rd        = AW'($urandom_range(0, 7));
            bus_a.flush_i      = ($urandom_range(0, 11) == 0);
            check_outputs("rand");
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined CPU, sitting between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC/IF-ID stall controls. It extends plain EX/MEM and MEM/WB forwarding to NUM_SRC source operands and configurable register-address width. It also contains a sequential stall controller that inserts LOAD_LAT bubbles on a load-use dependency and can be aborted by a pipeline flush.

Parameters:
REG_AW, 5, register-address width in bits.
NUM_SRC, 2, number of source operands per instruction; must be 1..4.
LOAD_LAT, 1, bubbles inserted per load-use hazard; must be 1..7.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
id_rs  in  NUM_SRC*REG_AW  ID-stage source registers; operand i at bits [i*REG_AW +: REG_AW].
id_rs_used  in  NUM_SRC  bit i=1 when ID operand i is actually read.
ex_rs  in  NUM_SRC*REG_AW  EX-stage source registers, same packing as id_rs.
ex_memread  in  1  EX-stage instruction is a load.
ex_rd  in  REG_AW  EX-stage destination.
mem_regwrite  in  1  EX/MEM instruction writes the register file.
mem_rd  in  REG_AW  EX/MEM destination.
wb_regwrite  in  1  MEM/WB instruction writes the register file.
wb_rd  in  REG_AW  MEM/WB destination.
flush_i  in  1  taken branch/jump; kills IF/ID and ID/EX this cycle.
fwd_sel  out  2*NUM_SRC  per-operand mux select; operand i at bits [2i+1:2i].
stall_pc  out  1  hold PC.
stall_ifid  out  1  hold IF/ID register.
flush_idex  out  1  load a bubble into ID/EX.

Behaviour:
- Forwarding is combinational from the current inputs, with no latency. Encoding per operand:
  - 2'b00: register file.
  - 2'b10: EX/MEM result.
  - 2'b01: MEM/WB result.
  - 2'b11: never produced.
- Forwarding priority, per operand i:
  - 2'b10 if mem_regwrite, mem_rd!=0 and mem_rd==ex_rs[i].
  - Otherwise 2'b01 if wb_regwrite, wb_rd!=0 and wb_rd==ex_rs[i].
  - Otherwise 2'b00.
- Register 0 is never forwarded.
- hazard = ex_memread && ex_rd!=0 && any i with id_rs_used[i] && id_rs[i]==ex_rd.
- FSM states are IDLE and STALL, with a down-counter cnt of width ceil(log2(LOAD_LAT+1)).
- IDLE:
  - If hazard && !flush_i: assert stall_pc, stall_ifid and flush_idex in the same cycle (combinational).
  - On that condition, if LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; if LOAD_LAT==1, stay in IDLE.
  - Otherwise all three stall outputs are 0.
- STALL:
  - Assert all three stall outputs and decrement cnt each cycle.
  - When cnt==1, return to IDLE on the next edge.
  - Hazard re-detection is ignored while in STALL.
- Total bubbles per hazard = LOAD_LAT exactly.
- flush_i has priority over everything:
  - In any state, flush_i=1 forces stall_pc=stall_ifid=0 and flush_idex=1.
  - Next state is IDLE and cnt is cleared.
  - Simultaneous hazard and flush_i: no stall is started.
- Reset:
  - While rst_n=0 all outputs are forced 0, including fwd_sel=0.
  - At a rising edge with rst_n=0, state goes to IDLE and cnt to 0.
  - Reset during STALL abandons the remaining bubbles.
- Forwarding selects remain valid during STALL; they are computed from the live inputs.

Optional Feature:
STALL_CNT_EN: when defined, adds output stall_cnt (out, 32 bits).
- Increments by 1 on every cycle where stall_pc=1.
- Saturates at 32'hFFFF_FFFF.
- Cleared by reset.
When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority:
  - mem_regwrite=1, mem_rd=5, wb_regwrite=1, wb_rd=5, ex_rs={5,5} -> fwd_sel=4'b1010.
  - Same with mem_regwrite=0 -> fwd_sel=4'b0101.
- Register 0: mem_rd=0, wb_rd=0 with both regwrites=1, ex_rs={0,0} -> fwd_sel=4'b0000.
- Load-use, LOAD_LAT=1: ex_memread=1, ex_rd=7, id_rs[1]=7, id_rs_used=2'b10 -> stall outputs high for exactly 1 cycle, then 0 with the ID inputs advanced.
- Load-use, LOAD_LAT=3: same stimulus -> stall_pc high for exactly 3 consecutive cycles; with id_rs_used[1]=0 -> no stall.
- Flush abort, LOAD_LAT=3: flush_i=1 on 2nd stall cycle -> stall_pc=0 and flush_idex=1 that cycle; IDLE next; total stall_pc cycles = 1.
- Reset and counter:
  - rst_n=0 for one edge during STALL -> all outputs 0, and IDLE after release.
  - With STALL_CNT_EN defined, two LOAD_LAT=3 hazards -> stall_cnt=6.
